// File: rtl/proc_pkg.sv
// Shared constants and next-pc source encoding for the 8-bit processor core.
package proc_pkg;
  localparam int PC_W_DEFAULT        = 8;
  localparam int STACK_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_RET,
    NPC_CALL,
    NPC_JMP,
    NPC_INC
  } npc_src_t;
endpackage

// File: rtl/call_stack.sv
// Return-address LIFO. top/full/empty are combinational from registered state.
// Pushes when full and pops when empty are ignored; the caller flags the error.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          async_reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = depth[AW-1:0];
  assign top_idx = depth[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];
  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      depth       <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end
endmodule

// File: rtl/program_sequencer.sv
// Program counter and next-address select with call/return stack; pm_addr is combinational, pc lags it by one cycle.
// pm_ready=0 holds pc and ignores all strobes (wait-state memories).
module program_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W        = PC_W_DEFAULT,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT,
  parameter int SDW         = $clog2(STACK_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            async_reset_n,
  input  logic            jmp,
  input  logic            jmp_nz,
  input  logic            dont_jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [3:0]      ir_nibble,
  input  logic            pm_ready,
  output logic [PC_W-1:0] pm_addr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] from_PS,
  output logic [SDW-1:0]  stack_depth,
  output logic            stack_err
);
  npc_src_t        src;
  logic            push, pop, err_set;
  logic            full, empty;
  logic [PC_W-1:0] inc, target, top, nxt;

  assign inc     = pc + PC_W'(1);
  assign target  = {pc[PC_W-1:4], ir_nibble};
  assign from_PS = pc;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .push          (push),
    .pop           (pop),
    .push_data     (inc),
    .top           (top),
    .depth         (stack_depth),
    .full          (full),
    .empty         (empty)
  );

  // Simultaneous strobes fall through this priority chain silently.
  always_comb begin
    src     = NPC_INC;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (!pm_ready) begin
      src = NPC_HOLD;
    end else if (ret) begin
      if (!empty) begin
        src = NPC_RET;
        pop = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (call) begin
      src = NPC_CALL;
      if (!full) push = 1'b1;
      else       err_set = 1'b1;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      src = NPC_JMP;
    end
  end

  always_comb begin
    case (src)
      NPC_HOLD:          nxt = pc;
      NPC_RET:           nxt = top;
      NPC_CALL, NPC_JMP: nxt = target;
      default:           nxt = inc;
    endcase
    // Memory sees address 0 for the whole reset, not pc+1.
    pm_addr = async_reset_n ? nxt : '0;
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      pc        <= '0;
      stack_err <= 1'b0;
    end else begin
      pc <= nxt;
      if (err_set) stack_err <= 1'b1;
    end
  end
endmodule
